// File: rtl/cam_pkg.sv
// Shared definitions for the CAM match encoder: default depth and the
// issue-side state encoding.
package cam_pkg;

  localparam int CAM_DEPTH_DEFAULT = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } cam_state_e;

endpackage

// File: rtl/cam_prio_enc.sv
// Combinational lowest-set-bit finder: returns the index of the least
// significant set bit and whether any bit is set.
module cam_prio_enc
  import cam_pkg::*;
#(
  parameter int DEPTH  = CAM_DEPTH_DEFAULT,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]  vec_i,
  output logic [ADDR_W-1:0] idx_o,
  output logic              any_o
);

  // Scan from the top down so the lowest set bit is the last to win.
  always_comb begin
    idx_o = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = i[ADDR_W-1:0];
    end
  end

  assign any_o = |vec_i;

endmodule

// File: rtl/cam_match_encoder.sv
// Streams the set indices of a CAM match vector, lowest first, with an explicit
// miss beat for an all-zero vector. Define CAM_MATCH_ENC_COUNT_EN to add match_count_o.
module cam_match_encoder
  import cam_pkg::*;
#(
  parameter int DEPTH  = CAM_DEPTH_DEFAULT,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DEPTH-1:0]  match_vec_i,
  input  logic              match_valid_i,
  output logic              match_ready_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              addr_valid_o,
  input  logic              addr_ready_i,
  output logic              last_o,
  output logic              miss_o
`ifdef CAM_MATCH_ENC_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] match_count_o
`endif
);

  localparam logic [DEPTH-1:0] ONE = DEPTH'(1);

  cam_state_e        state_q, state_d;
  logic [DEPTH-1:0]  pending_q, pending_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              miss_q, miss_d;

  logic [DEPTH-1:0]  cur_mask, remain, enc_vec;
  logic [ADDR_W-1:0] enc_idx;
  logic              enc_any, enc_single, hs;

  assign cur_mask = ONE << addr_q;
  assign remain   = pending_q & ~cur_mask;
  // One encoder serves both the fresh vector and what is left after a beat.
  assign enc_vec  = (state_q == IDLE) ? match_vec_i : remain;
  assign enc_single = enc_any && ((enc_vec & (enc_vec - ONE)) == '0);
  assign hs       = valid_q && addr_ready_i;

  cam_prio_enc #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_prio_enc (
    .vec_i (enc_vec),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    addr_d    = addr_q;
    valid_d   = valid_q;
    last_d    = last_q;
    miss_d    = miss_q;
    case (state_q)
      IDLE: begin
        if (match_valid_i) begin
          pending_d = match_vec_i;
          addr_d    = enc_idx;
          valid_d   = 1'b1;
          last_d    = !enc_any || enc_single;
          miss_d    = !enc_any;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (hs) begin
          pending_d = remain;
          if (enc_any) begin
            addr_d = enc_idx;
            last_d = enc_single;
            miss_d = 1'b0;
          end else begin
            addr_d  = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            miss_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      miss_q    <= miss_d;
    end
  end

  assign match_ready_o = (state_q == IDLE);
  assign addr_o        = addr_q;
  assign addr_valid_o  = valid_q;
  assign last_o        = last_q;
  assign miss_o        = miss_q;

`ifdef CAM_MATCH_ENC_COUNT_EN
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  always_comb begin
    count_d = count_q;
    if (state_q == IDLE && match_valid_i) count_d = popcount(match_vec_i);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign match_count_o = count_q;
`endif

endmodule

// File: tb/tb_cam_match_encoder.sv
// Self-checking bench for cam_match_encoder: a queue of expected beats derived
// from each submitted vector, checked every valid cycle, plus literal checks.
module tb_cam_match_encoder;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [DEPTH-1:0]  match_vec_i;
  logic              match_valid_i;
  logic              match_ready_o;
  logic [ADDR_W-1:0] addr_o;
  logic              addr_valid_o;
  logic              addr_ready_i;
  logic              last_o;
  logic              miss_o;
`ifdef CAM_MATCH_ENC_COUNT_EN
  logic [$clog2(DEPTH+1)-1:0] match_count_o;
`endif

  cam_match_encoder #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .match_vec_i   (match_vec_i),
    .match_valid_i (match_valid_i),
    .match_ready_o (match_ready_o),
    .addr_o        (addr_o),
    .addr_valid_o  (addr_valid_o),
    .addr_ready_i  (addr_ready_i),
    .last_o        (last_o),
    .miss_o        (miss_o)
`ifdef CAM_MATCH_ENC_COUNT_EN
    ,
    .match_count_o (match_count_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    bit last;
    bit miss;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: every set bit becomes a beat in ascending order; the highest one is last.
  function automatic void expand(input logic [DEPTH-1:0] v);
    beat_t b;
    int hi;
    hi = -1;
    for (int i = 0; i < DEPTH; i++) if (v[i]) hi = i;
    if (hi < 0) begin
      b.addr = 0; b.last = 1'b1; b.miss = 1'b1;
      exp_q.push_back(b);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (v[i]) begin
          b.addr = i; b.last = (i == hi); b.miss = 1'b0;
          exp_q.push_back(b);
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else if (addr_valid_o) begin
      chk("busy_not_ready", match_ready_o, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        chk("beat_addr", addr_o, exp_q[0].addr);
        chk("beat_last", last_o, exp_q[0].last);
        chk("beat_miss", miss_o, exp_q[0].miss);
        if (addr_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  // Present a vector until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [DEPTH-1:0] v);
    bit acc;
    acc = 1'b0;
    match_vec_i   = v;
    match_valid_i = 1'b1;
    expand(v);
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = match_ready_o;
      @(posedge clk);
      #1;
    end
    match_valid_i = 1'b0;
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      if (!addr_valid_o && exp_q.size() == 0) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DEPTH-1:0] extra [3];
    extra[0] = 16'h8000; extra[1] = 16'h5555; extra[2] = 16'hC003;

    rst = 1'b1; match_vec_i = '0; match_valid_i = 1'b0; addr_ready_i = 1'b1;
    step(); step();
    chk("rst_valid", addr_valid_o, 0);
    chk("rst_addr",  addr_o, 0);
    chk("rst_last",  last_o, 0);
    chk("rst_miss",  miss_o, 0);
    chk("rst_ready", match_ready_o, 1);
`ifdef CAM_MATCH_ENC_COUNT_EN
    chk("rst_count", match_count_o, 0);
`endif
    rst = 1'b0;
    step();

    // Miss
    send(16'h0000);
    chk("miss_valid", addr_valid_o, 1);
    chk("miss_miss",  miss_o, 1);
    chk("miss_last",  last_o, 1);
    chk("miss_addr",  addr_o, 0);
    step();
    chk("miss_idle_valid", addr_valid_o, 0);
    chk("miss_idle_ready", match_ready_o, 1);

    // Single match
    send(16'h0001);
    chk("single_addr", addr_o, 0);
    chk("single_last", last_o, 1);
    chk("single_miss", miss_o, 0);
    drain();

    // Multi-match, no backpressure
    send(16'h8421);
    chk("multi_a0", addr_o, 0);
    chk("multi_l0", last_o, 0);
`ifdef CAM_MATCH_ENC_COUNT_EN
    chk("count_8421", match_count_o, 4);
`endif
    step();
    chk("multi_a1", addr_o, 5);
    step();
    chk("multi_a2", addr_o, 10);
    chk("multi_l2", last_o, 0);
    step();
    chk("multi_a3", addr_o, 15);
    chk("multi_l3", last_o, 1);
`ifdef CAM_MATCH_ENC_COUNT_EN
    chk("count_hold", match_count_o, 4);
`endif
    step();
    chk("multi_done_valid", addr_valid_o, 0);
    chk("multi_done_ready", match_ready_o, 1);
`ifdef CAM_MATCH_ENC_COUNT_EN
    send(16'h0000);
    chk("count_miss", match_count_o, 0);
    drain();
`endif

    // Backpressure
    addr_ready_i = 1'b0;
    send(16'h0006);
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_valid", addr_valid_o, 1);
      chk("bp_hold_addr",  addr_o, 1);
      if (k < 2) step();
    end
    addr_ready_i = 1'b1;
    step();
    chk("bp_next_addr", addr_o, 2);
    chk("bp_next_last", last_o, 1);
    drain();

    // Reset mid-stream
    send(16'hFFFF);
    step(); step();
    chk("rst_mid_addr", addr_o, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_valid", addr_valid_o, 0);
    chk("rst_mid_ready", match_ready_o, 1);
    send(16'h0100);
    chk("post_rst_addr", addr_o, 8);
    chk("post_rst_last", last_o, 1);
    drain();

    for (int k = 0; k < 3; k++) begin
      send(extra[k]);
      drain();
    end

    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
